// File: rtl/screenchar_pkg.sv
// Shared constants and FSM encoding for the screen character memory write path.
package screenchar_pkg;
  localparam int unsigned SCREEN_CELLS = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] DEFAULT_FILL_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    CLEAR
  } arb_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first set request strictly after rr_ptr, with wrap.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [2:0]         pick_idx,
  output logic               pick_valid
);
  int unsigned idx;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick[idx]  = 1'b1;
        pick_idx   = 3'(idx);
      end
    end
  end
endmodule

// File: rtl/screenchar_write_arbiter.sv
// Round-robin burst arbiter owning the screen character memory write port,
// with a whole-screen clear sequence that takes priority between bursts.
module screenchar_write_arbiter
  import screenchar_pkg::*;
#(
  parameter int unsigned        NUM_REQ   = 3,
  parameter int unsigned        MAX_BURST = 64,
  parameter logic [CHAR_W-1:0]  FILL_CHAR = DEFAULT_FILL_CHAR
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr_en,
  input  logic [ADDR_W*NUM_REQ-1:0]  wr_addr,
  input  logic [CHAR_W*NUM_REQ-1:0]  wr_data,
  input  logic [NUM_REQ-1:0]         wr_last,
  input  logic                       clear_start,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       clear_busy,
  output logic                       mem_wren,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [CHAR_W-1:0]          mem_data,
  output logic [2:0]                 grant_id
);
  arb_state_e          state, next_state;
  logic [2:0]          rr_ptr;
  logic                clear_pending;
  logic [8:0]          beat_cnt;
  logic [ADDR_W-1:0]   clr_addr;
  logic                armed;

  logic [NUM_REQ-1:0]  pick;
  logic [2:0]          pick_idx;
  logic                pick_valid;

  logic [ADDR_W-1:0]   sel_addr;
  logic [CHAR_W-1:0]   sel_data;
  logic                sel_en, sel_last, sel_req;
  logic                beat_ok, start_grant, burst_end, clear_done;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Only the granted port is visible; grant is one-hot or zero.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_en   = 1'b0;
    sel_last = 1'b0;
    sel_req  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = wr_addr[ADDR_W*i +: ADDR_W];
        sel_data = wr_data[CHAR_W*i +: CHAR_W];
        sel_en   = wr_en[i];
        sel_last = wr_last[i];
        sel_req  = req[i];
      end
    end
  end

  always_comb begin
    next_state  = state;
    start_grant = 1'b0;
    burst_end   = 1'b0;
    clear_done  = 1'b0;
    // armed is low during the grant cycle itself, so beats there are dropped
    beat_ok     = (state == BURST) && armed && sel_en;
    case (state)
      IDLE: begin
        if (clear_pending) begin
          next_state = CLEAR;
        end else if (pick_valid) begin
          next_state  = BURST;
          start_grant = 1'b1;
        end
      end
      BURST: begin
        if (beat_ok && (sel_last || beat_cnt == 9'(MAX_BURST - 1)))
          burst_end = 1'b1;
        else if (!sel_req)
          burst_end = 1'b1;
        if (burst_end)
          next_state = IDLE;
      end
      CLEAR: begin
        if (clr_addr == '1) begin
          clear_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant         <= '0;
      grant_id      <= '0;
      rr_ptr        <= 3'(NUM_REQ - 1);
      clear_pending <= 1'b0;
      beat_cnt      <= '0;
      clr_addr      <= '0;
      armed         <= 1'b0;
      mem_wren      <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
    end else begin
      mem_wren <= 1'b0;
      // A pulse landing on the final fill write is absorbed, not queued.
      if (clear_done)       clear_pending <= 1'b0;
      else if (clear_start) clear_pending <= 1'b1;

      if (start_grant) begin
        grant    <= pick;
        grant_id <= pick_idx;
        beat_cnt <= '0;
        armed    <= 1'b0;
      end
      if (state == BURST) armed <= 1'b1;

      if (beat_ok) begin
        mem_wren <= 1'b1;
        mem_addr <= sel_addr;
        mem_data <= sel_data;
        beat_cnt <= beat_cnt + 9'd1;
      end
      if (burst_end) begin
        grant  <= '0;
        rr_ptr <= grant_id;
      end

      if (state == CLEAR) begin
        mem_wren <= 1'b1;
        mem_addr <= clr_addr;
        mem_data <= FILL_CHAR;
        clr_addr <= clr_addr + 1'b1;
      end
    end
  end

  assign clear_busy = clear_pending;
endmodule

// File: tb/tb_screenchar_write_arbiter.sv
// Scoreboard bench: writer agents push expected beats, a negedge monitor pops and compares.
module tb_screenchar_write_arbiter;
  localparam int unsigned NR   = 3;
  localparam int unsigned MB   = 64;
  localparam logic [7:0]  FILL = 8'h20;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req, wr_en, wr_last, grant;
  logic [8*NR-1:0] wr_addr, wr_data;
  logic            clear_start, clear_busy, mem_wren;
  logic [7:0]      mem_addr, mem_data;
  logic [2:0]      grant_id;

  screenchar_write_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .FILL_CHAR(FILL)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last), .clear_start(clear_start), .grant(grant),
    .clear_busy(clear_busy), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_data(mem_data), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  fill_q[$];
  int          grant_log[$];
  bit          clr_pend_m;
  int unsigned last_served;
  int unsigned rem[NR], beats[NR];
  logic [7:0]  nxt_addr[NR], nxt_data[NR];
  bit          use_last[NR], armed_m[NR], exp_drop[NR];
  bit          fixed_noise;
  logic [NR-1:0] prev_req, prev_grant;
  int unsigned exp_g;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] bump(logic [7:0] d);
    logic [7:0] n;
    n = d + 8'd1;
    if (n == FILL) n = n + 8'd1;
    return n;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (grant == '0) && (exp_q.size() == 0) && (fill_q.size() == 0);
    for (int i = 0; i < NR; i++) if (rem[i] != 0) r = 0;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fill_q.delete();
    clr_pend_m  = 0;
    last_served = NR - 1;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; beats[i] = 0; armed_m[i] = 0; exp_drop[i] = 0;
    end
  endtask

  task automatic load(int p, logic [7:0] a, logic [7:0] d, int unsigned len, bit lst);
    nxt_addr[p] = a;
    nxt_data[p] = (d == FILL) ? bump(d) : d;
    rem[p]      = len;
    use_last[p] = lst;
  endtask

  // One writer agent per port; ungranted ports drive noise on every strobe.
  task automatic drive_all();
    for (int i = 0; i < NR; i++) begin
      if (exp_drop[i]) begin
        check("cap_release", grant[i], 0);
        exp_drop[i] = 0;
      end
      req[i]             = (rem[i] != 0);
      wr_en[i]           = fixed_noise ? 1'b1 : 1'($urandom);
      wr_last[i]         = 1'($urandom);
      wr_addr[8*i +: 8]  = fixed_noise ? 8'h10 : 8'($urandom);
      wr_data[8*i +: 8]  = 8'($urandom);
      if (!grant[i]) begin
        armed_m[i] = 0;
        beats[i]   = 0;
      end else if (!armed_m[i]) begin
        armed_m[i] = 1;
      end else if (rem[i] == 0) begin
        wr_en[i] = 1'b0;
      end else begin
        wr_en[i]          = 1'b1;
        wr_addr[8*i +: 8] = nxt_addr[i];
        wr_data[8*i +: 8] = nxt_data[i];
        wr_last[i]        = use_last[i] && (rem[i] == 1);
        exp_q.push_back({nxt_addr[i], nxt_data[i]});
        rem[i]--;
        beats[i]++;
        nxt_addr[i] = nxt_addr[i] + 8'd1;
        nxt_data[i] = bump(nxt_data[i]);
        if (beats[i] == MB && rem[i] != 0) exp_drop[i] = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    drive_all();
  endtask

  task automatic pulse_clear();
    bit was_pending;
    was_pending = clr_pend_m;
    if (!clr_pend_m) begin
      for (int a = 0; a < 256; a++) fill_q.push_back(8'(a));
      clr_pend_m = 1;
    end
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    if (!was_pending) check("busy_rise", clear_busy, 1);
  endtask

  task automatic wait_idle(string name, int unsigned budget);
    int unsigned n;
    n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    check(name, all_idle(), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (mem_wren) begin
        if (mem_data == FILL) begin
          if (fill_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fill_unexpected: got fill write at %0h expected none", mem_addr);
          end else begin
            check("fill_addr", mem_addr, fill_q.pop_front());
            check("fill_no_grant", grant, 0);
            check("fill_no_burst", exp_q.size(), 0);
            check("fill_busy", clear_busy, (mem_addr != 8'hFF));
            if (mem_addr == 8'hFF) clr_pend_m = 0;
          end
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL write_unexpected: got %0h<=%0h expected none", mem_addr, mem_data);
        end else begin
          check("burst_write", {mem_addr, mem_data}, exp_q.pop_front());
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        exp_g = NR;
        for (int k = NR; k >= 1; k--)
          if (prev_req[(last_served + k) % NR]) exp_g = (last_served + k) % NR;
        check("grant_order", grant, (exp_g < NR) ? (32'd1 << exp_g) : 32'd0);
        check("grant_id", grant_id, exp_g);
        last_served = exp_g;
        grant_log.push_back(int'(exp_g));
      end else if (grant != '0 && grant != prev_grant) begin
        check("grant_gap", grant, prev_grant);
      end
    end
    prev_req   = req;
    prev_grant = grant;
  end

  initial begin
    int exp_order[4];
    int unsigned n;
    bit reloaded;
    reset_n = 1'b0; clear_start = 1'b0; fixed_noise = 0;
    req = '0; wr_en = '0; wr_last = '0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", grant, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_gid", grant_id, 0);
    reset_n = 1'b1;
    cycle();

    // single requester, three beats
    load(1, 8'h3C, 8'h31, 3, 1);
    cycle();
    cycle();
    check("t1_grant", grant, 3'b010);
    wait_idle("t1_idle", 200);

    // all three requesting, 2-beat bursts, port 0 re-requests
    do_reset();
    grant_log.delete();
    load(0, 8'h00, 8'h41, 2, 1);
    load(1, 8'h08, 8'h51, 2, 1);
    load(2, 8'h10, 8'h61, 2, 1);
    reloaded = 0; n = 0;
    while (!all_idle() && n < 400) begin
      cycle(); n++;
      if (!reloaded && grant_log.size() >= 2) begin
        load(0, 8'h04, 8'h71, 2, 1);
        reloaded = 1;
      end
    end
    check("t2_idle", all_idle(), 1);
    exp_order = '{0, 1, 2, 0};
    check("t2_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int k = 0; k < 4; k++) check("t2_order", grant_log[k], exp_order[k]);

    // 70-beat stream hits the burst cap
    grant_log.delete();
    load(2, 8'h80, 8'h90, 70, 0);
    n = 0;
    while (grant[2] !== 1'b1 && n < 50) begin cycle(); n++; end
    check("t3_granted", grant[2], 1);
    load(0, 8'h20, 8'hA0, 4, 1);
    load(1, 8'h30, 8'hB0, 3, 0);
    wait_idle("t3_idle", 600);
    exp_order = '{2, 0, 1, 2};
    check("t3_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      for (int k = 0; k < 4; k++) check("t3_order", grant_log[k], exp_order[k]);

    // clear during a burst, second pulse absorbed
    grant_log.delete();
    load(1, 8'h40, 8'hC0, 10, 1);
    n = 0;
    while (beats[1] < 3 && n < 50) begin cycle(); n++; end
    check("t4_beats", beats[1] >= 3, 1);
    load(0, 8'h50, 8'hD0, 3, 1);
    pulse_clear();
    n = 0;
    while (fill_q.size() > 150 && n < 400) begin cycle(); n++; end
    pulse_clear();
    check("t4_absorb", fill_q.size() <= 150, 1);
    wait_idle("t4_idle", 800);
    check("t4_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t4_first", grant_log[0], 1);
      check("t4_after", grant_log[1], 0);
    end

    // ungranted ports hammer address 0x10
    fixed_noise = 1;
    load(1, 8'h60, 8'hE0, 6, 1);
    wait_idle("t5_idle", 200);
    fixed_noise = 0;

    // randomized traffic with occasional clears
    for (int c = 0; c < 1500; c++) begin
      cycle();
      for (int p = 0; p < NR; p++)
        if (rem[p] == 0 && grant[p] == 1'b0 && $urandom_range(0, 9) == 0)
          load(p, 8'($urandom), 8'($urandom), $urandom_range(1, 80), 1'($urandom));
      if ($urandom_range(0, 299) == 0) pulse_clear();
    end
    wait_idle("rand_idle", 3000);

    // reset in the middle of a clear
    pulse_clear();
    n = 0;
    while (fill_q.size() > 128 && n < 400) begin cycle(); n++; end
    reset_n = 1'b0;
    cycle();
    check("t6_wren", mem_wren, 0);
    check("t6_busy", clear_busy, 0);
    check("t6_grant", grant, 0);
    model_reset();
    reset_n = 1'b1;
    repeat (300) cycle();
    check("final_drained", exp_q.size() + fill_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
